// File: rtl/multiword_adder_sequencer.sv
// Multi-word add/subtract built from one N-bit ripple-carry slice reused over WORDS cycles,
// least-significant slice first, with valid/ready handshakes on operand and result sides.
module multiword_adder_sequencer #(
    parameter int unsigned N     = 8,
    parameter int unsigned WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*WORDS-1:0]   a,
    input  logic [N*WORDS-1:0]   b,
    input  logic                 c_in,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*WORDS-1:0]   s,
    output logic                 c_out,
    output logic                 ovf
);

    localparam int unsigned W  = N * WORDS;
    localparam int unsigned IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  s_q, s_d;
    logic          c_out_q, c_out_d;
    logic          ovf_q, ovf_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;

    logic [N-1:0]  a_sl, b_sl, sum;
    logic          add_co, rc;
    logic          last;

    // Slice mux and the shared N-bit ripple-carry adder
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int unsigned w = 0; w < WORDS; w++) begin
            if (idx_q == IW'(w)) begin
                a_sl = a_q[w*N +: N];
                b_sl = b_q[w*N +: N];
            end
        end
        sum = '0;
        rc  = carry_q;
        for (int unsigned i = 0; i < N; i++) begin
            sum[i] = a_sl[i] ^ b_sl[i] ^ rc;
            rc     = (a_sl[i] & b_sl[i]) | (rc & (a_sl[i] ^ b_sl[i]));
        end
        add_co = rc;
        last   = (idx_q == IW'(WORDS - 1));
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        carry_d   = carry_q;
        s_d       = s_q;
        c_out_d   = c_out_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : c_in;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int unsigned w = 0; w < WORDS; w++) begin
                    if (idx_q == IW'(w)) begin
                        s_d[w*N +: N] = sum;
                    end
                end
                carry_d = add_co;
                idx_d   = idx_q + IW'(1);
                if (last) begin
                    c_out_d = add_co;
                    // b_q already holds the effective (possibly inverted) operand
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (sum[N-1] != a_q[W-1]);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            s_q         <= '0;
            c_out_q     <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            s_q         <= s_d;
            c_out_q     <= c_out_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign s         = s_q;
    assign c_out     = c_out_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_multiword_adder_sequencer.sv
// Directed bench for multiword_adder_sequencer (N=8, WORDS=4) with hand-computed results.
module tb_multiword_adder_sequencer;

    localparam int unsigned N     = 8;
    localparam int unsigned WORDS = 4;
    localparam int unsigned W     = N * WORDS;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         c_out;
    logic         ovf;

    int n_checks = 0;
    int n_pass   = 0;

    multiword_adder_sequencer #(.N(N), .WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Accept one operand set, count edges (accept edge = 1) until out_valid, check, then drain.
    task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic tc, input logic ts,
                         input logic [W-1:0] es, input logic ec, input logic eo);
        int edges;
        @(negedge clk);
        a = ta; b = tb_; c_in = tc; sub = ts; in_valid = 1'b1;
        check({tag, "_in_ready_idle"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom; b = $urandom; c_in = ~tc; sub = ~ts;
        while (!out_valid && edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check({tag, "_latency"}, 64'(edges), 64'(WORDS + 1));
        check({tag, "_s"}, 64'(s), 64'(es));
        check({tag, "_c_out"}, 64'(c_out), 64'(ec));
        check({tag, "_ovf"}, 64'(ovf), 64'(eo));
        check({tag, "_in_ready_done"}, 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_out_valid_drop"}, 64'(out_valid), 64'd0);
        check({tag, "_in_ready_back"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_s", 64'(s), 64'd0);
        check("rst_c_out", 64'(c_out), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);

        do_op("add_ff_1",   32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        do_op("add_ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        do_op("sub_5_7",    32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        do_op("sub_7_5",    32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
        do_op("add_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        do_op("sub_ovf",    32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        do_op("add_cin",    32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0, 32'h0000_0031, 1'b0, 1'b0);
        do_op("sub_cin_ign",32'h0000_0005, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0);

        // Back-pressure: hold the result in DONE while the producer pokes in_valid
        begin
            int waited;
            @(negedge clk);
            a = 32'h1; b = 32'h2; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            waited = 0;
            while (!out_valid && waited < 20) begin
                @(posedge clk);
                waited++;
                @(negedge clk);
            end
            check("stall_reach_done", 64'(out_valid), 64'd1);
            for (int k = 0; k < 10; k++) begin
                in_valid = k[0];
                a = 32'hDEAD_0000 + 32'(k); b = 32'h0BAD_0000;
                @(posedge clk);
                @(negedge clk);
                check("stall_out_valid", 64'(out_valid), 64'd1);
                check("stall_s", 64'(s), 64'd3);
                check("stall_in_ready", 64'(in_ready), 64'd0);
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_ready = 1'b0;
            check("stall_release_valid", 64'(out_valid), 64'd0);
            check("stall_release_ready", 64'(in_ready), 64'd1);
        end
        do_op("after_stall", 32'h0000_0100, 32'h0000_0200, 1'b0, 1'b0, 32'h0000_0300, 1'b0, 1'b0);

        // Reset mid-RUN while idx==2 discards the partial result
        @(negedge clk);
        a = 32'hAAAA_AAAA; b = 32'h5555_5555; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_run_out_valid", 64'(out_valid), 64'd0);
        check("rst_run_s", 64'(s), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_run_in_ready", 64'(in_ready), 64'd1);
        check("rst_run_valid_after", 64'(out_valid), 64'd0);
        do_op("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
